// File: rtl/ternary_fir_pkg.sv
// Shared types and helpers for the ternary-coefficient FIR family.
package ternary_fir_pkg;

    // Ternary coefficient: 01 = +1, 11 = -1, 00 = 0, 10 reserved (acts as 0)
    typedef logic signed [1:0] coef_t;

    localparam coef_t COEF_ZERO = 2'sb00;
    localparam coef_t COEF_POS  = 2'sb01;
    localparam coef_t COEF_NEG  = 2'sb11;

    // Channel tag width, never narrower than one bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Multiply a sign-extended sample by a ternary coefficient
    function automatic logic signed [31:0] tern_mul(input coef_t c, input logic signed [31:0] x);
        case (c)
            COEF_POS: return x;
            COEF_NEG: return -x;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/ternary_fir_mc_if.sv
// Sample / coefficient / result bundle for ternary_fir_mc.
interface ternary_fir_mc_if #(
    parameter int TAP_NUMBER   = 10,
    parameter int INPUT_LENGTH = 8,
    parameter int CHANNELS     = 4
) ();
    import ternary_fir_pkg::*;

    localparam int CH_W  = ch_width(CHANNELS);
    localparam int CN_W  = $clog2(TAP_NUMBER);
    localparam int OUT_W = INPUT_LENGTH + $clog2(TAP_NUMBER) + 1;

    logic signed [INPUT_LENGTH-1:0] In;
    logic                           in_valid;
    logic [CH_W-1:0]                in_ch;
    logic [CN_W-1:0]                Coef_Num;
    coef_t                          Coef_Val;
    logic                           Coef_w_en;
    logic                           Coef_commit;
    logic                           flush;
    logic signed [OUT_W-1:0]        Out;
    logic                           out_valid;
    logic [CH_W-1:0]                out_ch;

    modport master (
        output In, in_valid, in_ch, Coef_Num, Coef_Val, Coef_w_en, Coef_commit, flush,
        input  Out, out_valid, out_ch
    );

    modport slave (
        input  In, in_valid, in_ch, Coef_Num, Coef_Val, Coef_w_en, Coef_commit, flush,
        output Out, out_valid, out_ch
    );

endinterface

// File: rtl/ternary_fir_coef_bank.sv
// Double-buffered coefficient store: writes land in a shadow bank, and a
// commit copies the whole shadow bank (including a same-edge write) into
// the active bank in one edge.
module ternary_fir_coef_bank
    import ternary_fir_pkg::*;
#(
    parameter int TAP_NUMBER = 10,
    parameter int CN_W       = $clog2(TAP_NUMBER)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_w_en,
    input  logic [CN_W-1:0] i_num,
    input  coef_t           i_val,
    input  logic            i_commit,
    output coef_t           o_act [TAP_NUMBER]
);

    coef_t r_shadow     [TAP_NUMBER];
    coef_t r_act        [TAP_NUMBER];
    coef_t w_shadow_nxt [TAP_NUMBER];

    // Next shadow contents, so a commit can capture a write on the same edge
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (i_w_en && (32'(i_num) < TAP_NUMBER)) begin
            w_shadow_nxt[i_num] = i_val;
        end
    end

    // Shadow and active bank registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAP_NUMBER; i++) begin
                r_shadow[i] <= COEF_ZERO;
                r_act[i]    <= COEF_ZERO;
            end
        end else begin
            r_shadow <= w_shadow_nxt;
            if (i_commit) begin
                r_act <= w_shadow_nxt;
            end
        end
    end

    assign o_act = r_act;

endmodule

// File: rtl/ternary_fir_mc.sv
// Multi-channel two-stage ternary FIR: stage A shifts the tagged channel's
// delay line and captures its window, stage B sums the ternary products.
module ternary_fir_mc
    import ternary_fir_pkg::*;
#(
    parameter int TAP_NUMBER   = 10,
    parameter int INPUT_LENGTH = 8,
    parameter int CHANNELS     = 4
) (
    input logic                clk,
    input logic                rst,
    ternary_fir_mc_if.slave    bus
);

    localparam int CH_W  = ch_width(CHANNELS);
    localparam int CN_W  = $clog2(TAP_NUMBER);
    localparam int OUT_W = INPUT_LENGTH + $clog2(TAP_NUMBER) + 1;

    logic signed [INPUT_LENGTH-1:0] r_dl     [CHANNELS][TAP_NUMBER];
    logic signed [INPUT_LENGTH-1:0] r_win_p0 [TAP_NUMBER];
    logic                           r_vld_p0;
    logic [CH_W-1:0]                r_ch_p0;

    logic signed [OUT_W-1:0]        r_out_p1;
    logic                           r_vld_p1;
    logic [CH_W-1:0]                r_ch_p1;

    coef_t                          w_coef [TAP_NUMBER];
    logic                           w_accept;
    logic signed [31:0]             w_acc;
    logic signed [OUT_W-1:0]        w_sum;

    ternary_fir_coef_bank #(
        .TAP_NUMBER (TAP_NUMBER),
        .CN_W       (CN_W)
    ) u_coef_bank (
        .clk      (clk),
        .rst      (rst),
        .i_w_en   (bus.Coef_w_en),
        .i_num    (bus.Coef_Num),
        .i_val    (bus.Coef_Val),
        .i_commit (bus.Coef_commit),
        .o_act    (w_coef)
    );

    // A sample is taken only for an existing channel and never during flush
    assign w_accept = bus.in_valid && !bus.flush && (32'(bus.in_ch) < CHANNELS);

    // ---- stage A: per-channel delay line shift and window capture ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < TAP_NUMBER; i++) begin
                    r_dl[c][i] <= '0;
                end
            end
            for (int i = 0; i < TAP_NUMBER; i++) begin
                r_win_p0[i] <= '0;
            end
            r_vld_p0 <= 1'b0;
            r_ch_p0  <= '0;
        end else begin
            r_vld_p0 <= w_accept;
            if (bus.flush) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int i = 0; i < TAP_NUMBER; i++) begin
                        r_dl[c][i] <= '0;
                    end
                end
            end else if (w_accept) begin
                r_dl[bus.in_ch][0] <= bus.In;
                r_win_p0[0]        <= bus.In;
                for (int i = 1; i < TAP_NUMBER; i++) begin
                    r_dl[bus.in_ch][i] <= r_dl[bus.in_ch][i-1];
                    r_win_p0[i]        <= r_dl[bus.in_ch][i-1];
                end
                r_ch_p0 <= bus.in_ch;
            end
        end
    end

    // Ternary products summed at full width; the result always fits OUT_W
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < TAP_NUMBER; i++) begin
            w_acc = w_acc + tern_mul(w_coef[i], 32'(r_win_p0[i]));
        end
    end

    assign w_sum = OUT_W'(w_acc);

    // ---- stage B: output register, holds its value while idle ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_p1 <= '0;
            r_vld_p1 <= 1'b0;
            r_ch_p1  <= '0;
        end else begin
            r_vld_p1 <= r_vld_p0;
            if (r_vld_p0) begin
                r_out_p1 <= w_sum;
                r_ch_p1  <= r_ch_p0;
            end
        end
    end

    assign bus.Out       = r_out_p1;
    assign bus.out_valid = r_vld_p1;
    assign bus.out_ch    = r_ch_p1;

endmodule
